latch_bank_wr_sched: RTL and testbench

//  Write scheduler for a latch-based storage bank built from LASX2-style

---
 rtl/latch_bank_wr_sched_pkg.sv | 29 ++
 rtl/latch_bank_wr_sched_rr_arb.sv | 34 +++
 rtl/latch_bank_wr_sched.sv | 152 +++++++++++++++
 tb/tb_latch_bank_wr_sched.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/latch_bank_wr_sched_pkg.sv
// Shared types and constants for the latch bank write scheduler.
// Optional build macro LATCH_WR_PARITY_EN widens the latch data bus by one parity bit.
package latch_bank_wr_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        OPEN   = 3'd2,
        HOLD   = 3'd3,
        PRESET = 3'd4,
        RECOV  = 3'd5
    } state_t;

    localparam int PRESET_CYC = 1;
    localparam int RECOV_CYC  = 1;
    // Phase counter width; bounds HOLD_CYC, PRESET_CYC and RECOV_CYC to 256.
    localparam int CNT_W      = 8;

`ifdef LATCH_WR_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/latch_bank_wr_sched_rr_arb.sv
// Purpose: round-robin pick of the first request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller only consumes the winner when it can start a write.
module lbws_rr_arb
    import latch_bank_wr_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = addr_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [IW-1:0]   win_idx,
    output logic            win_vld
);

    logic [IW-1:0] idx;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!win_vld && req[idx]) begin
                win_vld     = 1'b1;
                win_oh[idx] = 1'b1;
                win_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/latch_bank_wr_sched.sv
// Purpose: round-robin write scheduler and SETB preset sequencer for a latch bank (macro LATCH_WR_PARITY_EN adds parity MSB on lat_d).
// Latency: gnt 1 cycle after an IDLE request, lat_en 1 cycle later, then HOLD_CYC hold cycles; preset_done 3 cycles after IDLE.
// Backpressure: req/preset_req are levels held by the requester; only sampled in IDLE, never aborting a write in flight.
module latch_bank_wr_sched
    import latch_bank_wr_sched_pkg::*;
#(
    parameter  int NREQ     = 4,
    parameter  int DEPTH    = 8,
    parameter  int WIDTH    = 8,
    parameter  int HOLD_CYC = 1,
    localparam int AW       = addr_w(DEPTH),
    localparam int IW       = addr_w(NREQ),
    localparam int DW       = WIDTH + PAR_W
) (
    input  logic                  CLK,
    input  logic                  RSTB,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    input  logic                  preset_req,
    output logic                  preset_done,
    output logic [DEPTH-1:0]      lat_en,
    output logic                  lat_setb,
    output logic [DW-1:0]         lat_d,
    output logic                  wr_err,
    output logic                  busy
);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IW-1:0]     ptr;
    logic [AW-1:0]     addr_q;
    logic              rst_recov;
    logic [NREQ-1:0]   win_oh;
    logic [IW-1:0]     win_idx;
    logic              win_vld;
    logic [NREQ-1:0]   gnt_nxt;
    logic [DEPTH-1:0]  lat_en_nxt;
    logic              wr_err_nxt;
    logic              done_nxt;
    logic              capture;
    logic [AW-1:0]     addr_arr [NREQ];
    logic [WIDTH-1:0]  data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*AW +: AW];
        assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end

    lbws_rr_arb #(.NREQ(NREQ)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        gnt_nxt    = '0;
        lat_en_nxt = '0;
        wr_err_nxt = 1'b0;
        done_nxt   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (preset_req) begin
                    state_nxt = PRESET;
                    cnt_nxt   = CNT_W'(PRESET_CYC - 1);
                end else if (win_vld) begin
                    state_nxt = SETUP;
                    gnt_nxt   = win_oh;
                    capture   = 1'b1;
                end
            end
            SETUP: begin
                state_nxt = OPEN;
                if (int'(addr_q) < DEPTH) begin
                    for (int d = 0; d < DEPTH; d++)
                        lat_en_nxt[d] = (int'(addr_q) == d);
                end else begin
                    wr_err_nxt = 1'b1;
                end
            end
            OPEN: begin
                state_nxt = HOLD;
                cnt_nxt   = CNT_W'(HOLD_CYC - 1);
            end
            HOLD: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            PRESET: begin
                if (cnt == '0) begin
                    state_nxt = RECOV;
                    cnt_nxt   = CNT_W'(RECOV_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RECOV: begin
                // The recovery entered from reset finishes silently.
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = !rst_recov;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state       <= RECOV;
            cnt         <= '0;
            ptr         <= '0;
            addr_q      <= '0;
            rst_recov   <= 1'b1;
            gnt         <= '0;
            preset_done <= 1'b0;
            lat_en      <= '0;
            lat_setb    <= 1'b0;
            lat_d       <= '0;
            wr_err      <= 1'b0;
            busy        <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            gnt         <= gnt_nxt;
            preset_done <= done_nxt;
            lat_en      <= lat_en_nxt;
            lat_setb    <= (state_nxt != PRESET);
            wr_err      <= wr_err_nxt;
            busy        <= (state_nxt != IDLE);
            if (state_nxt != RECOV) rst_recov <= 1'b0;
            if (capture) begin
                addr_q <= addr_arr[win_idx];
                ptr    <= (int'(win_idx) == NREQ - 1) ? '0 : win_idx + IW'(1);
`ifdef LATCH_WR_PARITY_EN
                lat_d  <= {^data_arr[win_idx], data_arr[win_idx]};
`else
                lat_d  <= data_arr[win_idx];
`endif
            end
        end
    end

endmodule

// File: tb/tb_latch_bank_wr_sched.sv
// Directed bench for latch_bank_wr_sched: reset, round-robin order, write timeline, preset, out-of-range, async reset, parity.
// A DEPTH=6 twin shares all inputs so an out-of-range address (7) is representable with the same 3-bit address bus.
module tb_latch_bank_wr_sched;
    import latch_bank_wr_sched_pkg::*;

    localparam int NREQ  = 4;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int AW    = 3;
    localparam int DW    = WIDTH + PAR_W;

    logic                  CLK;
    logic                  RSTB;
    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  preset_req;

    logic [NREQ-1:0]  gnt, gnt_b;
    logic             preset_done, preset_done_b;
    logic [DEPTH-1:0] lat_en;
    logic [5:0]       lat_en_b;
    logic             lat_setb, lat_setb_b;
    logic [DW-1:0]    lat_d, lat_d_b;
    logic             wr_err, wr_err_b;
    logic             busy, busy_b;

    int checks = 0;
    int errors = 0;

    latch_bank_wr_sched #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH), .HOLD_CYC(1)) dut (
        .CLK(CLK), .RSTB(RSTB), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .preset_req(preset_req), .preset_done(preset_done), .lat_en(lat_en),
        .lat_setb(lat_setb), .lat_d(lat_d), .wr_err(wr_err), .busy(busy)
    );

    latch_bank_wr_sched #(.NREQ(NREQ), .DEPTH(6), .WIDTH(WIDTH), .HOLD_CYC(1)) dut_b (
        .CLK(CLK), .RSTB(RSTB), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt_b), .preset_req(preset_req), .preset_done(preset_done_b), .lat_en(lat_en_b),
        .lat_setb(lat_setb_b), .lat_d(lat_d_b), .wr_err(wr_err_b), .busy(busy_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        req_addr[i*AW +: AW]       = a;
        req_data[i*WIDTH +: WIDTH] = d;
    endtask

    initial begin
        logic [31:0] par07;
`ifdef LATCH_WR_PARITY_EN
        par07 = 32'h107;
`else
        par07 = 32'h007;
`endif
        RSTB = 1'b0; req = '0; req_addr = '0; req_data = '0; preset_req = 1'b0;

        // Reset state, then release with no requests.
        repeat (2) @(negedge CLK);
        chk("rst_lat_setb", lat_setb, 0);
        chk("rst_busy", busy, 1);
        chk("rst_gnt", gnt, 0);
        chk("rst_lat_en", lat_en, 0);
        chk("rst_lat_d", lat_d, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_preset_done", preset_done, 0);
        RSTB = 1'b1;
        tick();
        chk("rel_busy", busy, 0);
        chk("rel_lat_setb", lat_setb, 1);
        chk("rel_preset_done", preset_done, 0);
        tick();
        chk("rel_preset_done2", preset_done, 0);

        // All four requesting: grants 0,1,2,3,0 every 4 cycles.
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), WIDTH'(8'h11 * (i + 1)));
        req = 4'b1111;
        for (int k = 1; k <= 17; k++) begin
            int g;
            tick();
            g = ((k - 1) / 4) % 4;
            chk("rr_gnt", gnt, (k % 4 == 1) ? (32'd1 << g) : 32'd0);
            chk("rr_lat_d", lat_d, 32'h11 * (g + 1));
            chk("rr_lat_en", lat_en, (k % 4 == 2) ? (32'd1 << (g + 1)) : 32'd0);
        end
        req = '0;
        repeat (3) tick();
        chk("rr_idle", busy, 0);

        // Single write: req[2], addr 5, data A5.
        set_req(2, 3'd5, 8'hA5);
        req = 4'b0100;
        tick();
        chk("wr_gnt", gnt, 4'b0100);
        chk("wr_d_t1", lat_d, 8'hA5);
        chk("wr_en_t1", lat_en, 0);
        req = '0;
        tick();
        chk("wr_en_t2", lat_en, 8'h20);
        chk("wr_gnt_t2", gnt, 0);
        tick();
        chk("wr_en_t3", lat_en, 0);
        chk("wr_d_t3", lat_d, 8'hA5);
        chk("wr_busy_t3", busy, 1);
        tick();
        chk("wr_busy_t4", busy, 0);

        // Preset wins over a simultaneous req[0].
        set_req(0, 3'd3, 8'h3C);
        req = 4'b0001;
        preset_req = 1'b1;
        tick();
        chk("pr_setb_low", lat_setb, 0);
        chk("pr_gnt", gnt, 0);
        chk("pr_en", lat_en, 0);
        preset_req = 1'b0;
        tick();
        chk("pr_setb_recov", lat_setb, 1);
        chk("pr_done_early", preset_done, 0);
        tick();
        chk("pr_done", preset_done, 1);
        chk("pr_gnt_wait", gnt, 0);
        tick();
        chk("pr_done_off", preset_done, 0);
        chk("pr_gnt_after", gnt, 4'b0001);
        req = '0;
        tick();
        chk("pr_wr_en", lat_en, 8'h08);
        chk("pr_wr_setb", lat_setb, 1);
        repeat (2) tick();
        chk("pr_idle", busy, 0);

        // Out-of-range address on the DEPTH=6 twin.
        set_req(1, 3'd7, 8'h5A);
        req = 4'b0010;
        tick();
        chk("oor_gnt", gnt_b, 4'b0010);
        chk("oor_err_t1", wr_err_b, 0);
        req = '0;
        tick();
        chk("oor_err", wr_err_b, 1);
        chk("oor_en", lat_en_b, 0);
        chk("inr_en", lat_en, 8'h80);
        chk("inr_err", wr_err, 0);
        tick();
        chk("oor_err_off", wr_err_b, 0);
        tick();
        chk("oor_idle", busy_b, 0);

        // Reset asserted mid-OPEN.
        set_req(0, 3'd4, 8'h99);
        req = 4'b0001;
        tick();
        chk("ar_gnt", gnt, 4'b0001);
        req = '0;
        tick();
        chk("ar_en_open", lat_en, 8'h10);
        #2 RSTB = 1'b0;
        #1;
        chk("ar_en_async", lat_en, 0);
        chk("ar_setb_async", lat_setb, 0);
        chk("ar_busy_async", busy, 1);
        @(negedge CLK);
        RSTB = 1'b1;
        chk("ar_busy_recov", busy, 1);
        tick();
        chk("ar_busy_idle", busy, 0);
        chk("ar_setb_idle", lat_setb, 1);
        chk("ar_no_done", preset_done, 0);

        // Pointer restarts at 0 after reset; data 07 exercises parity.
        set_req(1, 3'd6, 8'h07);
        set_req(3, 3'd0, 8'hFF);
        req = 4'b1010;
        tick();
        chk("ptr_rst_gnt", gnt, 4'b0010);
        chk("par_lat_d", lat_d, par07);
        req = '0;
        tick();
        chk("par_en", lat_en, 8'h40);
        repeat (2) tick();
        chk("final_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
